nv_ram_rwsp_pinit: RTL and testbench
====================================

NV_RAM_RWSP_PINIT -- requirements
Module: nv_ram_rwsp_pinit

Interface
REQ-001 The block SHALL expose these parameters, one per line: name, default, meaning.
- WIDTH, 14, data bits per word
- DEPTH, 16, number of words (need not be a power of 2)
- AW, 4, address bits; ceil(log2(DEPTH)) <= AW
- BYPASS, 1, 1 = write-to-read forwarding on address collision; 0 = return old contents

REQ-002 The block SHALL expose these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state on rising edge
- rstn  in  1  reset, asynchronous assert, active-low
- ra  in  AW  read address
- re  in  1  read-address capture enable
- ore  in  1  output-register enable
- dout  out  WIDTH  registered read data
- dout_vld  out  1  dout holds data from an accepted read
- wa  in  AW  write address
- we  in  1  write enable
- di  in  WIDTH  write data
- clr_req  in  1  one-cycle pulse requesting a full-array clear
- clr_busy  out  1  clear in progress; user accesses blocked
- pwrbus_ram_pd  in  32  power-down bus; functionally ignored

Function
REQ-003 Storage SHALL be DEPTH x WIDTH words; contents SHALL NOT be reset directly, only by the clear FSM.
REQ-004 FSM states SHALL be CLEAR and IDLE; clr_busy SHALL be 1 exactly when in CLEAR.
REQ-005 In CLEAR: counter clr_addr writes all-zero to word clr_addr, one word per cycle, from 0 to DEPTH-1; after writing DEPTH-1 -> IDLE; CLEAR lasts exactly DEPTH cycles.
REQ-006 IDLE -> CLEAR on clr_req=1, clr_addr restarting at 0; clr_req in CLEAR SHALL be ignored.
REQ-007 In CLEAR, user we and re SHALL be ignored; ra_d holds; rd_v1 forced 0.
REQ-008 In IDLE, we=1 with wa<DEPTH SHALL write di to word wa at the clock edge; wa>=DEPTH writes SHALL be dropped.
REQ-009 Read stage 1: in IDLE, re=1 SHALL capture ra into ra_d; rd_v1 SHALL be loaded with re every IDLE cycle.
REQ-010 Read stage 2: ore=1 SHALL load dout with word ra_d (0 if ra_d>=DEPTH) and dout_vld with rd_v1; ore=0 SHALL hold dout and dout_vld.
REQ-011 Latency: re at edge N and ore at edge N+1 SHALL present data at dout, with dout_vld=1, after edge N+1.
REQ-012 Collision: if at an ore edge, in IDLE, we=1 and wa==ra_d<DEPTH, then dout SHALL get di when BYPASS=1, and the pre-write word when BYPASS=0.
REQ-013 Collision with the clear write (CLEAR, ore=1, clr_addr==ra_d) SHALL return 0 when BYPASS=1.
REQ-014 A read captured before a clear starts and output during CLEAR SHALL set dout_vld=0 (rd_v1 forced 0); dout SHALL still update per REQ-010.
REQ-015 Simultaneous re and we in IDLE to different addresses SHALL both take effect.
REQ-016 pwrbus_ram_pd SHALL have no functional effect.

Reset
REQ-017 rstn=0 SHALL immediately force: dout=0, dout_vld=0, ra_d=0, rd_v1=0, clr_addr=0, state=CLEAR (clr_busy=1).
REQ-018 After rstn deassert, the block SHALL run a full DEPTH-cycle clear, then enter IDLE with all words 0.
REQ-019 Reset asserted mid-clear or mid-read SHALL abort the operation and restart per REQ-017/018.

Verification
REQ-020 Post-reset, default params: clr_busy=1 for exactly 16 cycles then 0; reading each of words 0..15 -> dout=0, dout_vld=1.
REQ-021 Write 0x2A5B to word 5; next cycle re with ra=5, then ore -> dout=0x2A5B, dout_vld=1 two edges after re.
REQ-022 Word 3 holds 0x0111; ra_d=3 and, at the ore edge, we=1, wa=3, di=0x1FFF -> dout=0x1FFF with BYPASS=1, 0x0111 with BYPASS=0; word 3 then reads 0x1FFF.
REQ-023 re captured, then ore held 0 for 3 cycles -> dout/dout_vld unchanged; ore=1 -> data appears.
REQ-024 IDLE, words written non-zero; clr_req pulse -> 16 busy cycles, we during busy dropped, clr_req during busy ignored; afterwards all words read 0.
REQ-025 DEPTH=12, AW=4: write to wa=13 dropped; read ra=13 -> dout=0, dout_vld=1; clear lasts 12 cycles; rstn pulsed at clear cycle 5 -> clear restarts from 0.

Source files
------------

// File: rtl/nv_ram_rwsp_pinit.sv
// Single-port-per-direction RAM with a registered two-stage read path and a
// clear FSM that zeroes every word after reset or on request.
module nv_ram_rwsp_pinit #(
    parameter int WIDTH  = 14,
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [AW-1:0]    ra,
    input  logic             re,
    input  logic             ore,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic [AW-1:0]    wa,
    input  logic             we,
    input  logic [WIDTH-1:0] di,
    input  logic             clr_req,
    output logic             clr_busy,
    input  logic [31:0]      pwrbus_ram_pd
);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [AW-1:0]    clr_addr;
    logic [AW-1:0]    ra_d;
    logic             rd_v1;
    logic             in_clear;
    logic             wr_user;
    logic             ra_hit;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] mem [DEPTH];

    // The power-down bus is carried for integration only.
    logic unused_pwrbus;
    assign unused_pwrbus = ^pwrbus_ram_pd;

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values, which the read-during-write path relies on.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_addr == LAST_ADDR) state_nxt = IDLE;
            IDLE:    if (clr_req) state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        in_clear = (state == CLEAR);
        clr_busy = in_clear;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clr_addr <= '0;
        end else if (in_clear) begin
            clr_addr <= (clr_addr == LAST_ADDR) ? '0 : clr_addr + 1'b1;
        end else begin
            clr_addr <= '0;
        end
    end

    assign wr_user = !in_clear && we && ({1'b0, wa} < DEPTH_W);
    assign ra_hit  = ({1'b0, ra_d} < DEPTH_W);

    // NOTE: the array is deliberately left out of reset; the clear FSM zeroes
    // it one word per cycle, which keeps it mappable onto a RAM macro.
    always_ff @(posedge clk) begin
        if (in_clear) begin
            mem[clr_addr] <= '0;
        end else if (wr_user) begin
            mem[wa] <= di;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ra_d  <= '0;
            rd_v1 <= 1'b0;
        end else if (in_clear) begin
            rd_v1 <= 1'b0;
        end else begin
            rd_v1 <= re;
            if (re) ra_d <= ra;
        end
    end

    // Same-edge writes are forwarded so a colliding read sees the new word.
    always_comb begin
        rd_word = '0;
        if (ra_hit) begin
            if (BYPASS != 0 && wr_user && wa == ra_d) begin
                rd_word = di;
            end else if (BYPASS != 0 && in_clear && clr_addr == ra_d) begin
                rd_word = '0;
            end else begin
                rd_word = mem[ra_d];
            end
        end
    end

    // A read still pending when a clear starts is reported as invalid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout     <= '0;
            dout_vld <= 1'b0;
        end else if (ore) begin
            dout     <= rd_word;
            dout_vld <= rd_v1 && !in_clear;
        end
    end

endmodule

// File: tb/tb_nv_ram_rwsp_pinit.sv
// Bench for nv_ram_rwsp_pinit: a default instance checked against a word-level
// model under directed and random traffic, plus a DEPTH=12 / BYPASS=0 instance.
module tb_nv_ram_rwsp_pinit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: defaults (16 words, forwarding on).
    logic        rstn_a;
    logic [3:0]  ra_a, wa_a;
    logic        re_a, ore_a, we_a, clr_a;
    logic [13:0] di_a, dout_a;
    logic        vld_a, busy_a;
    logic [31:0] pwr_a;

    nv_ram_rwsp_pinit dut_a (
        .clk(clk), .rstn(rstn_a), .ra(ra_a), .re(re_a), .ore(ore_a),
        .dout(dout_a), .dout_vld(vld_a), .wa(wa_a), .we(we_a), .di(di_a),
        .clr_req(clr_a), .clr_busy(busy_a), .pwrbus_ram_pd(pwr_a)
    );

    // Instance B: 12 words, 4 address bits, old data on collision.
    logic        rstn_b;
    logic [3:0]  ra_b, wa_b;
    logic        re_b, ore_b, we_b, clr_b;
    logic [13:0] di_b, dout_b;
    logic        vld_b, busy_b;
    logic [31:0] pwr_b;

    nv_ram_rwsp_pinit #(.WIDTH(14), .DEPTH(12), .AW(4), .BYPASS(0)) dut_b (
        .clk(clk), .rstn(rstn_b), .ra(ra_b), .re(re_b), .ore(ore_b),
        .dout(dout_b), .dout_vld(vld_b), .wa(wa_b), .we(we_b), .di(di_b),
        .clr_req(clr_b), .clr_busy(busy_b), .pwrbus_ram_pd(pwr_b)
    );

    // Reference model for instance A, kept at word/transaction level.
    logic [13:0] m_mem [16];
    int          m_left;
    logic [3:0]  m_ra;
    logic        m_rv;
    logic [13:0] m_dout;
    logic        m_vld;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic i_re, input logic i_ore, input logic i_we, input logic i_clr,
                        input logic [3:0] i_ra, input logic [3:0] i_wa, input logic [13:0] i_di);
        int w;
        re_a = i_re; ore_a = i_ore; we_a = i_we; clr_a = i_clr;
        ra_a = i_ra; wa_a = i_wa; di_a = i_di; pwr_a = $urandom;
        if (m_left > 0) begin
            w = 16 - m_left;
            if (i_ore) begin
                m_dout = (int'(m_ra) == w) ? 14'h0 : m_mem[m_ra];
                m_vld  = 1'b0;
            end
            m_mem[w] = 14'h0;
            m_left--;
            m_rv = 1'b0;
        end else begin
            if (i_ore) begin
                m_dout = (i_we && i_wa == m_ra) ? i_di : m_mem[m_ra];
                m_vld  = m_rv;
            end
            if (i_we) m_mem[i_wa] = i_di;
            m_rv = i_re;
            if (i_re) m_ra = i_ra;
            if (i_clr) m_left = 16;
        end
        tick();
        check("a_busy", 32'(busy_a), 32'(m_left > 0));
        check("a_dout", 32'(dout_a), 32'(m_dout));
        check("a_vld", 32'(vld_a), 32'(m_vld));
    endtask

    task automatic idle_a();
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 14'h0);
    endtask

    task automatic read_a(input logic [3:0] addr);
        step(1'b1, 1'b0, 1'b0, 1'b0, addr, 4'h0, 14'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 14'h0);
    endtask

    task automatic reset_a();
        int n;
        re_a = 1'b0; ore_a = 1'b0; we_a = 1'b0; clr_a = 1'b0;
        rstn_a = 1'b0;
        #1;
        check("a_rst_busy", 32'(busy_a), 32'd1);
        check("a_rst_dout", 32'(dout_a), 32'd0);
        check("a_rst_vld", 32'(vld_a), 32'd0);
        m_left = 16; m_rv = 1'b0; m_ra = 4'h0; m_dout = 14'h0; m_vld = 1'b0;
        for (int i = 0; i < 16; i++) m_mem[i] = 14'h3FFF;
        tick();
        rstn_a = 1'b1;
        n = 0;
        while (busy_a === 1'b1 && n < 100) begin
            n++;
            idle_a();
        end
        check("a_clear_len", 32'(n), 32'd16);
    endtask

    task automatic step_b(input logic i_re, input logic i_ore, input logic i_we, input logic i_clr,
                          input logic [3:0] i_ra, input logic [3:0] i_wa, input logic [13:0] i_di);
        re_b = i_re; ore_b = i_ore; we_b = i_we; clr_b = i_clr;
        ra_b = i_ra; wa_b = i_wa; di_b = i_di;
        tick();
    endtask

    task automatic reset_b();
        int n;
        re_b = 1'b0; ore_b = 1'b0; we_b = 1'b0; clr_b = 1'b0;
        rstn_b = 1'b0;
        #1;
        check("b_rst_busy", 32'(busy_b), 32'd1);
        check("b_rst_dout", 32'(dout_b), 32'd0);
        check("b_rst_vld", 32'(vld_b), 32'd0);
        tick();
        rstn_b = 1'b1;
        n = 0;
        while (busy_b === 1'b1 && n < 100) begin
            n++;
            step_b(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 14'h0);
        end
        check("b_clear_len", 32'(n), 32'd12);
    endtask

    initial begin
        int n;
        rstn_a = 1'b0; rstn_b = 1'b0;
        ra_a = 4'h0; wa_a = 4'h0; di_a = 14'h0; pwr_a = 32'h0;
        re_a = 1'b0; ore_a = 1'b0; we_a = 1'b0; clr_a = 1'b0;
        ra_b = 4'h0; wa_b = 4'h0; di_b = 14'h0; pwr_b = 32'hFFFF_FFFF;
        re_b = 1'b0; ore_b = 1'b0; we_b = 1'b0; clr_b = 1'b0;

        // Power-on clear, then every word reads back zero and valid.
        reset_a();
        for (int i = 0; i < 16; i++) begin
            read_a(4'(i));
            check("a_init_word", 32'(dout_a), 32'd0);
            check("a_init_vld", 32'(vld_a), 32'd1);
        end

        // Write, then read with re/ore on consecutive edges.
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h5, 14'h2A5B);
        read_a(4'h5);
        check("a_wr_rd", 32'(dout_a), 32'h2A5B);
        check("a_wr_rd_vld", 32'(vld_a), 32'd1);

        // Collision at the ore edge is forwarded, and the write lands.
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h3, 14'h0111);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'h0, 14'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h3, 14'h1FFF);
        check("a_bypass", 32'(dout_a), 32'h1FFF);
        read_a(4'h3);
        check("a_bypass_after", 32'(dout_a), 32'h1FFF);

        // ore low holds the output; valid drops on a read without a fresh re.
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 14'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h5, 4'h0, 14'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'h5, 4'h0, 14'h0);
        check("a_hold_dout", 32'(dout_a), 32'h1FFF);
        check("a_hold_vld", 32'(vld_a), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 14'h0);
        check("a_release_dout", 32'(dout_a), 32'h2A5B);
        check("a_release_vld", 32'(vld_a), 32'd1);

        // Read captured as a clear starts; user traffic and clr_req during the clear.
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'h5, 4'h0, 14'h0);
        n = 0;
        while (busy_a === 1'b1 && n < 100) begin
            n++;
            step(1'b1, 1'b1, 1'b1, 1'b1, 4'h7, 4'h7, 14'h1234);
            if (n == 1) check("a_clr_stale_vld", 32'(vld_a), 32'd0);
        end
        check("a_req_clear_len", 32'(n), 32'd16);
        for (int i = 0; i < 16; i++) begin
            read_a(4'(i));
            check("a_post_clear", 32'(dout_a), 32'd0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 39) == 0), 4'($urandom), 4'($urandom), 14'($urandom));
        end
        while (m_left > 0) idle_a();

        // Reset arriving with a read in flight.
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h9, 14'h1555);
        read_a(4'h9);
        check("a_pre_rst", 32'(dout_a), 32'h1555);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h9, 4'h0, 14'h0);
        reset_a();
        read_a(4'h9);
        check("a_after_rst", 32'(dout_a), 32'd0);

        // Instance B: non-power-of-2 depth, no forwarding.
        reset_b();
        step_b(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'hD, 14'h3FFF);
        step_b(1'b1, 1'b0, 1'b0, 1'b0, 4'hD, 4'h0, 14'h0);
        step_b(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 14'h0);
        check("b_oob_dout", 32'(dout_b), 32'd0);
        check("b_oob_vld", 32'(vld_b), 32'd1);
        step_b(1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 4'h0, 14'h0);
        step_b(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 14'h0);
        check("b_no_alias", 32'(dout_b), 32'd0);

        step_b(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h3, 14'h0111);
        step_b(1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'h0, 14'h0);
        step_b(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h3, 14'h1FFF);
        check("b_old_data", 32'(dout_b), 32'h0111);
        step_b(1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'h0, 14'h0);
        step_b(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 14'h0);
        check("b_new_data", 32'(dout_b), 32'h1FFF);

        // Reset pulsed at clear cycle 5 restarts a full clear.
        step_b(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'hB, 14'h0ABC);
        step_b(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 14'h0);
        for (int i = 0; i < 4; i++) step_b(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 14'h0);
        check("b_mid_clear_busy", 32'(busy_b), 32'd1);
        reset_b();
        step_b(1'b1, 1'b0, 1'b0, 1'b0, 4'hB, 4'h0, 14'h0);
        step_b(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 14'h0);
        check("b_word11_cleared", 32'(dout_b), 32'd0);
        check("b_word11_vld", 32'(vld_b), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
